// File: rtl/switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// switch_allocator_rr
//
// Per-output switch allocator for an N-port wormhole router. Each input port
// presents a one-hot output request; every output arbitrates among its
// requesters with its own round-robin pointer. A head flit that is not also a
// tail locks the output to its input until the tail flit has crossed. Grants,
// crossbar selects and valids are combinational from the current state and
// inputs. Arbitration state changes only on the rising clock edge.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset; forces every output to 0
//   i_output_req   [i][j] input i requests output j (one-hot, all-zero = idle)
//   i_tail         [i] flit at the head of input i is a tail / single flit
//   i_output_full  [j] output j has no downstream space this cycle
//   o_input_grant  [i] input i's flit crosses the crossbar this cycle
//   o_xbar_valid   [j] output j carries a flit this cycle
//   o_xbar_sel     [j] source input index for output j (0 when not valid)
//   o_locked       [j] output j is held by an in-flight packet
// -----------------------------------------------------------------------------
module switch_allocator_rr #(
    parameter int N     = 5,
    parameter int X_LOC = 0,
    parameter int Y_LOC = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [0:N-1][0:N-1]           i_output_req,
    input  logic [0:N-1]                  i_tail,
    input  logic [0:N-1]                  i_output_full,
    output logic [0:N-1]                  o_input_grant,
    output logic [0:N-1]                  o_xbar_valid,
    output logic [0:N-1][$clog2(N)-1:0]   o_xbar_sel,
    output logic [0:N-1]                  o_locked
);

    localparam int SW = $clog2(N);

    // The router coordinates only matter for instantiation symmetry with the
    // routing stage; a negative coordinate would be a mesh misconfiguration.
    if (X_LOC < 0 || Y_LOC < 0) begin : g_neg_coord
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state_q [N];
    state_t        state_d [N];
    logic [SW-1:0] owner_q [N];
    logic [SW-1:0] owner_d [N];
    logic [SW-1:0] ptr_q   [N];
    logic [SW-1:0] ptr_d   [N];

    // req_col[j][i]: input i has a valid (filtered) request for output j
    logic [N-1:0]  req_col [N];
    logic          seen;

    logic [N-1:0]  gnt_in;
    logic [N-1:0]  valid_c;
    logic [SW-1:0] sel_c [N];
    logic          found;
    logic [SW-1:0] win;
    int            idx;

    // Request filtering: keep only the lowest set bit of each input's request,
    // then drop U-turns (input i back to output i), except on the local port.
    always_comb begin
        seen = 1'b0;
        for (int j = 0; j < N; j++) begin
            req_col[j] = '0;
        end
        for (int i = 0; i < N; i++) begin
            seen = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (i_output_req[i][j] && !seen) begin
                    seen = 1'b1;
                    if (i == 0 || j != i) begin
                        req_col[j][i] = 1'b1;
                    end
                end
            end
        end
    end

    // Per-output arbitration and next-state computation
    always_comb begin
        gnt_in  = '0;
        valid_c = '0;
        found   = 1'b0;
        win     = '0;
        idx     = 0;
        for (int j = 0; j < N; j++) begin
            sel_c[j]   = '0;
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
        end

        for (int j = 0; j < N; j++) begin
            if (state_q[j] == ST_IDLE) begin
                if (!i_output_full[j]) begin
                    // Scan from the pointer upward with wrap; first hit wins.
                    found = 1'b0;
                    win   = '0;
                    for (int k = 0; k < N; k++) begin
                        idx = (int'(ptr_q[j]) + k) % N;
                        if (!found && req_col[j][idx]) begin
                            found = 1'b1;
                            win   = SW'(idx);
                        end
                    end
                    if (found) begin
                        valid_c[j]  = 1'b1;
                        sel_c[j]    = win;
                        gnt_in[win] = 1'b1;
                        ptr_d[j]    = SW'((int'(win) + 1) % N);
                        if (!i_tail[win]) begin
                            state_d[j] = ST_LOCKED;
                            owner_d[j] = win;
                        end
                    end
                end
            end else begin
                // Locked: only the owner may use the output. A bubble or a
                // full output simply skips the cycle with the lock kept.
                if (req_col[j][owner_q[j]] && !i_output_full[j]) begin
                    valid_c[j]          = 1'b1;
                    sel_c[j]            = owner_q[j];
                    gnt_in[owner_q[j]]  = 1'b1;
                    if (i_tail[owner_q[j]]) begin
                        state_d[j] = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= ST_IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end

    // Outputs are forced low for as long as reset is held, whatever the inputs.
    always_comb begin
        o_input_grant = '0;
        o_xbar_valid  = '0;
        o_locked      = '0;
        for (int j = 0; j < N; j++) begin
            o_xbar_sel[j] = '0;
        end
        if (reset_n) begin
            for (int j = 0; j < N; j++) begin
                o_input_grant[j] = gnt_in[j];
                o_xbar_valid[j]  = valid_c[j];
                o_xbar_sel[j]    = sel_c[j];
                o_locked[j]      = (state_q[j] == ST_LOCKED);
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator_rr.sv
// -----------------------------------------------------------------------------
// tb_switch_allocator_rr
//
// Bench for switch_allocator_rr (N=5). A table of per-cycle vectors (inputs
// plus hand-derived expected grant/valid/sel/locked) is applied in order from
// reset; expectations go into a queue when the inputs are driven and are
// popped and compared mid-cycle. Hand-written sequences cover reset during an
// active packet lock.
// -----------------------------------------------------------------------------
module tb_switch_allocator_rr;

    localparam int N = 5;

    logic                clk;
    logic                reset_n;
    logic [0:N-1][0:N-1] i_output_req;
    logic [0:N-1]        i_tail;
    logic [0:N-1]        i_output_full;
    logic [0:N-1]        o_input_grant;
    logic [0:N-1]        o_xbar_valid;
    logic [0:N-1][2:0]   o_xbar_sel;
    logic [0:N-1]        o_locked;

    switch_allocator_rr #(.N(N), .X_LOC(0), .Y_LOC(0)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_output_req  (i_output_req),
        .i_tail        (i_tail),
        .i_output_full (i_output_full),
        .o_input_grant (o_input_grant),
        .o_xbar_valid  (o_xbar_valid),
        .o_xbar_sel    (o_xbar_sel),
        .o_locked      (o_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit k of every mask field refers to port k (input for req/tail/grant,
    // output for full/valid/locked). req[i] bit j = input i requests output j.
    typedef struct {
        string            name;
        logic [4:0][4:0]  req;
        logic [4:0]       tail;
        logic [4:0]       full;
        logic [4:0]       grant;
        logic [4:0]       valid;
        logic [4:0]       locked;
        logic [4:0][2:0]  sel;
    } vec_t;

    vec_t tbl [$];
    vec_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string nm, int t0, int t1, int t2, int t3, int t4,
                                logic [4:0] tl, logic [4:0] fl,
                                logic [4:0] gr, logic [4:0] va, logic [4:0] lk,
                                int s0, int s1, int s2, int s3, int s4);
        vec_t v;
        int   t [5];
        int   s [5];
        t = '{t0, t1, t2, t3, t4};
        s = '{s0, s1, s2, s3, s4};
        v.name   = nm;
        v.tail   = tl;
        v.full   = fl;
        v.grant  = gr;
        v.valid  = va;
        v.locked = lk;
        for (int i = 0; i < 5; i++) begin
            v.req[i] = (t[i] >= 0) ? 5'(1 << t[i]) : 5'b0;
            v.sel[i] = 3'(s[i]);
        end
        return v;
    endfunction

    task automatic drive(input vec_t v);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                i_output_req[i][j] = v.req[i][j];
            end
            i_tail[i]        = v.tail[i];
            i_output_full[i] = v.full[i];
        end
    endtask

    task automatic cmp(input string nm, input string what,
                       input logic [14:0] act, input logic [14:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, what, act, req);
        end
    endtask

    task automatic check_out();
        vec_t            e;
        logic [4:0]      ag;
        logic [4:0]      av;
        logic [4:0]      al;
        logic [4:0][2:0] as;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard actual=empty required=entry");
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++) begin
            ag[i] = o_input_grant[i];
            av[i] = o_xbar_valid[i];
            al[i] = o_locked[i];
            as[i] = o_xbar_sel[i];
        end
        cmp(e.name, "grant",  {10'b0, ag}, {10'b0, e.grant});
        cmp(e.name, "valid",  {10'b0, av}, {10'b0, e.valid});
        cmp(e.name, "locked", {10'b0, al}, {10'b0, e.locked});
        cmp(e.name, "sel",    as, e.sel);
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        vec_t zero;
        vec_t v;

        idle = mk("idle", -1, -1, -1, -1, -1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 0, 0, 0, 0, 0);

        // Contention: inputs 1,2,3 -> output 0, single-flit packets
        tbl.push_back(mk("idle0", -1, -1, -1, -1, -1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("A1", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b00010, 5'b00001, 5'b0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("A2", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b00100, 5'b00001, 5'b0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("A3", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b01000, 5'b00001, 5'b0, 3, 0, 0, 0, 0));
        tbl.push_back(mk("A4", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b00010, 5'b00001, 5'b0, 1, 0, 0, 0, 0));
        tbl.push_back(mk("A5", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b00100, 5'b00001, 5'b0, 2, 0, 0, 0, 0));
        tbl.push_back(mk("A6", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b01000, 5'b00001, 5'b0, 3, 0, 0, 0, 0));
        // Wormhole: input 2 sends 3 flits to output 4; input 0 waits; output 0 independent
        tbl.push_back(mk("B1", -1, -1, 4, -1, -1, 5'b00000, 5'b0, 5'b00100, 5'b10000, 5'b00000, 0, 0, 0, 0, 2));
        tbl.push_back(mk("B2", 4, 0, 4, -1, -1, 5'b00011, 5'b0, 5'b00110, 5'b10001, 5'b10000, 1, 0, 0, 0, 2));
        tbl.push_back(mk("B3", 4, -1, 4, -1, -1, 5'b00101, 5'b0, 5'b00100, 5'b10000, 5'b10000, 0, 0, 0, 0, 2));
        tbl.push_back(mk("B4", 4, -1, -1, -1, -1, 5'b00001, 5'b0, 5'b00001, 5'b10000, 5'b00000, 0, 0, 0, 0, 0));
        // Backpressure and bubble on locked output 1 (owner 3), intruder input 4
        tbl.push_back(mk("C1", -1, -1, -1, 1, -1, 5'b00000, 5'b00000, 5'b01000, 5'b00010, 5'b00000, 0, 3, 0, 0, 0));
        tbl.push_back(mk("C2", -1, -1, -1, 1, 1, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 0, 0, 0, 0, 0));
        tbl.push_back(mk("C3", -1, -1, -1, 1, 1, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 5'b00010, 0, 0, 0, 0, 0));
        tbl.push_back(mk("C4", -1, -1, -1, 1, 1, 5'b10000, 5'b00000, 5'b01000, 5'b00010, 5'b00010, 0, 3, 0, 0, 0));
        tbl.push_back(mk("C5", -1, -1, -1, -1, 1, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00010, 0, 0, 0, 0, 0));
        tbl.push_back(mk("C6", -1, -1, -1, 1, 1, 5'b11000, 5'b00000, 5'b01000, 5'b00010, 5'b00010, 0, 3, 0, 0, 0));
        tbl.push_back(mk("C7", -1, -1, -1, -1, 1, 5'b10000, 5'b00000, 5'b10000, 5'b00010, 5'b00000, 0, 4, 0, 0, 0));
        tbl.push_back(mk("C8", -1, -1, -1, -1, 1, 5'b10000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 0, 0, 0, 0, 0));
        // Pointer wrap on output 2: input 3 wins (ptr=4), then 4, then 0
        tbl.push_back(mk("D1", -1, -1, -1, 2, -1, 5'b01000, 5'b0, 5'b01000, 5'b00100, 5'b0, 0, 0, 3, 0, 0));
        tbl.push_back(mk("D2", 2, -1, -1, -1, 2, 5'b11111, 5'b0, 5'b10000, 5'b00100, 5'b0, 0, 0, 4, 0, 0));
        tbl.push_back(mk("D3", 2, -1, -1, -1, 2, 5'b11111, 5'b0, 5'b00001, 5'b00100, 5'b0, 0, 0, 0, 0, 0));
        // Filtering: input 3 U-turn ignored, input 1 multi-bit request -> output 2
        v = mk("E1", -1, -1, -1, 3, -1, 5'b11111, 5'b0, 5'b00010, 5'b00100, 5'b0, 0, 0, 1, 0, 0);
        v.req[1] = 5'b01100;
        tbl.push_back(v);
        v = mk("E2", 0, -1, -1, 3, -1, 5'b11111, 5'b0, 5'b00011, 5'b00101, 5'b0, 0, 0, 1, 0, 0);
        v.req[1] = 5'b01100;
        tbl.push_back(v);
        // Lock output 0 to input 2 ahead of the reset sequence
        tbl.push_back(mk("F1", -1, -1, 0, -1, -1, 5'b00000, 5'b0, 5'b00100, 5'b00001, 5'b00000, 2, 0, 0, 0, 0));

        // Reset asserted with live requests: every output must read 0
        reset_n = 1'b0;
        zero = mk("rst_init", -1, 0, 0, 0, -1, 5'b11111, 5'b0, 5'b0, 5'b0, 5'b0, 0, 0, 0, 0, 0);
        drive(zero);
        #12;
        exp_q.push_back(zero);
        check_out();
        drive(idle);
        #10;
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            run_vec(tbl[k]);
        end

        // Output 0 is now locked by input 2; drop reset in mid-packet
        run_vec(mk("F2", -1, -1, 0, -1, -1, 5'b00000, 5'b0, 5'b00100, 5'b00001, 5'b00001, 2, 0, 0, 0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(mk("rst_mid", -1, -1, 0, -1, -1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 0, 0, 0, 0, 0));
        check_out();
        drive(idle);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        run_vec(mk("post_rst", -1, -1, -1, -1, -1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 0, 0, 0, 0, 0));
        // Pointer back at 0 and lock dropped: input 1 beats input 4
        run_vec(mk("F3", -1, 0, -1, -1, 0, 5'b11111, 5'b0, 5'b00010, 5'b00001, 5'b00000, 1, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator_rr.md
Name: switch_allocator_rr

Overview:
Per-output-port switch allocator, directly downstream of the output-port selection stage in each router. It consumes the one-hot output requests produced per input port and arbitrates each output among competing inputs with a round-robin pointer. It holds a wormhole lock from head flit to tail flit and drives the crossbar select and per-input grant signals for the current cycle.

Parameters:
N, `N (5), number of router ports; port 0 = local, 1..N-1 = neighbour directions.
X_LOC, 0, X coordinate of this router; carried for instantiation symmetry, unused in logic.
Y_LOC, 0, Y coordinate of this router; carried for instantiation symmetry, unused in logic.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  reset; asynchronous assert, active-low.
i_output_req  input  [0:N-1][0:N-1]  per input i, one-hot requested output; all-zero = no flit. Driven by selection stage o_output_req.
i_tail  input  [0:N-1]  flit at head of input i is a tail (or single-flit packet).
i_output_full  input  [0:N-1]  output j has no downstream credit/space this cycle.
o_input_grant  output  [0:N-1]  input i's flit crosses the crossbar this cycle (pop input buffer).
o_xbar_valid  output  [0:N-1]  output j carries a flit this cycle.
o_xbar_sel  output  [0:N-1][$clog2(N)-1:0]  source input index for output j; 0 when o_xbar_valid[j]=0.
o_locked  output  [0:N-1]  output j is held by an in-flight packet (debug/verification).

Behaviour:
- Per output j: state IDLE or LOCKED, owner[j] ($clog2(N) bits), rr_ptr[j] ($clog2(N) bits).
- Reset (reset_n=0, any time including mid-packet): all outputs IDLE, owner=0, rr_ptr=0. All outputs read 0 while reset is asserted, regardless of inputs. An in-flight packet lock is dropped.
- Grants are combinational from current state and inputs, with zero-cycle latency. State changes only on clk.
- Request filtering:
  - If i_output_req[i] has more than one bit set, only the lowest-index set bit counts.
  - A request from input i to output i for i≠0 (U-turn) is ignored.
- IDLE, output j, i_output_full[j]=0:
  - Winner = first requesting input scanning rr_ptr[j], rr_ptr[j]+1, …, wrapping N-1→0.
  - Grant the winner: o_xbar_valid[j]=1, o_xbar_sel[j]=winner, o_input_grant[winner]=1.
  - At the clock edge, rr_ptr[j] ← (winner+1) mod N.
  - If i_tail[winner]=0: go to LOCKED with owner ← winner.
  - If i_tail[winner]=1 (single-flit packet): stay IDLE.
- IDLE with i_output_full[j]=1: no grant, no state or pointer change.
- LOCKED, output j:
  - Grant only if owner still requests j and i_output_full[j]=0. Requests from all other inputs to j are refused.
  - A granted flit with i_tail[owner]=1 returns j to IDLE at the edge. rr_ptr is not changed on tail; it was already advanced at the head grant.
  - If the owner drops its request (bubble) or the output is full: no grant, lock held.
- Each input requests one output, so no input is granted by two outputs in a cycle. o_input_grant[i] is the OR over j of the grants to i.
- Outputs are independent. Different outputs can grant different inputs in the same cycle.
- o_locked[j] = (state[j]==LOCKED).

Test Plan:
- Reset then idle: reset_n low mid-run with a LOCKED output → all outputs 0 immediately. After release, all o_locked=0, rr_ptr=0.
- Contention: inputs 1,2,3 request output 0 with i_tail=1 every cycle, i_output_full=0 → o_xbar_sel[0] sequence 1,2,3,1,2,3, one grant per cycle.
- Wormhole lock: input 2 sends a 3-flit packet to output 4 (tail on the 3rd flit) while input 0 also requests output 4 → input 2 is granted for 3 cycles, input 0 on the 4th. o_locked[4]=1 during cycles 2–3.
- Backpressure: LOCKED output 1, i_output_full[1]=1 for 2 cycles → o_input_grant=0 and o_xbar_valid[1]=0, lock kept. The remaining flits are granted once full deasserts.
- Wrap-around: rr_ptr[3]=4 with inputs 0 and 4 requesting output 3 → input 4 wins, rr_ptr[3] becomes 0, next cycle input 0 wins.
- Filtering: input 3 requests output 3 (U-turn) → never granted. Input 1 drives req=5'b01100 → treated as a request for output 2 only.
